// File: rtl/lsu.sv
// Load/store unit: takes one memory operation at a time from execute,
// issues a word-aligned bus request with byte strobes, and returns
// extended load data on the register-file write port.
module lsu #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [REG_AW-1:0] req_rd,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic [XLEN-1:0]   bus_addr,
    output logic              bus_we,
    output logic [3:0]        bus_wstrb,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata,
    output logic              mem_write_en,
    output logic [REG_AW-1:0] mem_write_addr,
    output logic [XLEN-1:0]   mem_write_data,
    output logic              misaligned,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [2:0]        funct3_reg, funct3_next;
    logic [1:0]        off_reg, off_next;
    logic [REG_AW-1:0] rd_reg, rd_next;
    logic              bus_valid_reg, bus_valid_next;
    logic [XLEN-1:0]   bus_addr_reg, bus_addr_next;
    logic              bus_we_reg, bus_we_next;
    logic [3:0]        bus_wstrb_reg, bus_wstrb_next;
    logic [XLEN-1:0]   bus_wdata_reg, bus_wdata_next;
    logic              wb_en_reg, wb_en_next;
    logic [REG_AW-1:0] wb_addr_reg, wb_addr_next;
    logic [XLEN-1:0]   wb_data_reg, wb_data_next;
    logic              misaligned_reg, misaligned_next;

    // Replicated store lanes: byte copied to all four lanes, halfword to both halves
    logic [XLEN-1:0] byte_lanes;
    logic [XLEN-1:0] half_lanes;
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign byte_lanes[8*gi +: 8] = req_wdata[7:0];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half_lane
            assign half_lanes[16*gi +: 16] = req_wdata[15:0];
        end
    endgenerate

    // Request classification
    logic is_half, is_word, illegal_op, misaligned_op;
    assign is_half       = (req_funct3[1:0] == 2'b01);
    assign is_word       = (req_funct3[1:0] == 2'b10);
    assign illegal_op    = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110) ||
                           (req_we && req_funct3[2]);
    assign misaligned_op = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));

    // Load data shifted so the addressed byte sits in lane 0, then extended
    logic [XLEN-1:0] rdata_shifted;
    logic [XLEN-1:0] load_result;
    assign rdata_shifted = bus_rdata >> {off_reg, 3'b000};

    // Extension by latched width/sign code
    always_comb begin
        load_result = rdata_shifted;
        case (funct3_reg[1:0])
            2'b00: load_result = funct3_reg[2] ? {{(XLEN-8){1'b0}}, rdata_shifted[7:0]}
                                               : {{(XLEN-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
            2'b01: load_result = funct3_reg[2] ? {{(XLEN-16){1'b0}}, rdata_shifted[15:0]}
                                               : {{(XLEN-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_result = rdata_shifted;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_next      = state_reg;
        funct3_next     = funct3_reg;
        off_next        = off_reg;
        rd_next         = rd_reg;
        bus_valid_next  = bus_valid_reg;
        bus_addr_next   = bus_addr_reg;
        bus_we_next     = bus_we_reg;
        bus_wstrb_next  = bus_wstrb_reg;
        bus_wdata_next  = bus_wdata_reg;
        wb_en_next      = 1'b0;
        wb_addr_next    = wb_addr_reg;
        wb_data_next    = wb_data_reg;
        misaligned_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (illegal_op) begin
                        // dropped silently
                    end else if (misaligned_op) begin
                        misaligned_next = 1'b1;
                    end else begin
                        funct3_next    = req_funct3;
                        off_next       = req_addr[1:0];
                        rd_next        = req_rd;
                        bus_valid_next = 1'b1;
                        bus_addr_next  = {req_addr[XLEN-1:2], 2'b00};
                        bus_we_next    = req_we;
                        bus_wstrb_next = 4'b0000;
                        bus_wdata_next = '0;
                        if (req_we) begin
                            case (req_funct3[1:0])
                                2'b00: begin
                                    bus_wstrb_next = 4'b0001 << req_addr[1:0];
                                    bus_wdata_next = byte_lanes;
                                end
                                2'b01: begin
                                    bus_wstrb_next = 4'b0011 << req_addr[1:0];
                                    bus_wdata_next = half_lanes;
                                end
                                default: begin
                                    bus_wstrb_next = 4'b1111;
                                    bus_wdata_next = req_wdata;
                                end
                            endcase
                        end
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (bus_ready) begin
                    bus_valid_next = 1'b0;
                    state_next     = bus_we_reg ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (bus_rvalid) begin
                    // rd 0 must never produce a writeback strobe
                    wb_en_next   = (rd_reg != '0);
                    wb_addr_next = rd_reg;
                    wb_data_next = load_result;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next     = IDLE;
                bus_valid_next = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            funct3_reg     <= '0;
            off_reg        <= '0;
            rd_reg         <= '0;
            bus_valid_reg  <= 1'b0;
            bus_addr_reg   <= '0;
            bus_we_reg     <= 1'b0;
            bus_wstrb_reg  <= '0;
            bus_wdata_reg  <= '0;
            wb_en_reg      <= 1'b0;
            wb_addr_reg    <= '0;
            wb_data_reg    <= '0;
            misaligned_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            funct3_reg     <= funct3_next;
            off_reg        <= off_next;
            rd_reg         <= rd_next;
            bus_valid_reg  <= bus_valid_next;
            bus_addr_reg   <= bus_addr_next;
            bus_we_reg     <= bus_we_next;
            bus_wstrb_reg  <= bus_wstrb_next;
            bus_wdata_reg  <= bus_wdata_next;
            wb_en_reg      <= wb_en_next;
            wb_addr_reg    <= wb_addr_next;
            wb_data_reg    <= wb_data_next;
            misaligned_reg <= misaligned_next;
        end
    end

    assign req_ready      = (state_reg == IDLE);
    assign busy           = (state_reg != IDLE);
    assign bus_valid      = bus_valid_reg;
    assign bus_addr       = bus_addr_reg;
    assign bus_we         = bus_we_reg;
    assign bus_wstrb      = bus_wstrb_reg;
    assign bus_wdata      = bus_wdata_reg;
    assign mem_write_en   = wb_en_reg;
    assign mem_write_addr = wb_addr_reg;
    assign mem_write_data = wb_data_reg;
    assign misaligned     = misaligned_reg;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus tasks push expected bus requests,
// writebacks and misalignment pulses; a negedge monitor pops and compares.
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        mem_write_en;
    logic [4:0]  mem_write_addr;
    logic [31:0] mem_write_data;
    logic        misaligned;
    logic        busy;

    lsu #(.XLEN(32), .REG_AW(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rd         (req_rd),
        .bus_valid      (bus_valid),
        .bus_ready      (bus_ready),
        .bus_addr       (bus_addr),
        .bus_we         (bus_we),
        .bus_wstrb      (bus_wstrb),
        .bus_wdata      (bus_wdata),
        .bus_rvalid     (bus_rvalid),
        .bus_rdata      (bus_rdata),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .misaligned     (misaligned),
        .busy           (busy)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        int          cyc;
    } bus_exp_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } wb_exp_t;

    bus_exp_t bus_q[$];
    wb_exp_t  wb_q[$];
    int       mis_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare DUT outputs against queued expectations away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            if (bus_valid) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected", {31'd0, bus_valid}, 32'd0);
                end else begin
                    chk("bus_addr", bus_addr, bus_q[0].addr);
                    chk("bus_we", {31'd0, bus_we}, {31'd0, bus_q[0].we});
                    if (bus_q[0].we) begin
                        chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, bus_q[0].strb});
                        chk("bus_wdata", bus_wdata, bus_q[0].wdata);
                    end
                    if (bus_ready) begin
                        chk("bus_cycle", cyc, bus_q[0].cyc);
                        $display("bus  addr=0x%08h we=%0d strb=%b wdata=0x%08h cycle=%0d",
                                 bus_addr, bus_we, bus_wstrb, bus_wdata, cyc);
                        void'(bus_q.pop_front());
                    end
                end
            end
            if (mem_write_en) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", {31'd0, mem_write_en}, 32'd0);
                end else begin
                    chk("wb_addr", {27'd0, mem_write_addr}, {27'd0, wb_q[0].rd});
                    chk("wb_data", mem_write_data, wb_q[0].data);
                    chk("wb_cycle", cyc, wb_q[0].cyc);
                    $display("wb   rd=%0d data=0x%08h cycle=%0d", mem_write_addr, mem_write_data, cyc);
                    void'(wb_q.pop_front());
                end
            end
            if (misaligned) begin
                if (mis_q.size() == 0) begin
                    chk("mis_unexpected", {31'd0, misaligned}, 32'd0);
                end else begin
                    chk("mis_cycle", cyc, mis_q[0]);
                    $display("mis  cycle=%0d", cyc);
                    void'(mis_q.pop_front());
                end
            end
        end
    end

    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd, output int t0);
        @(posedge clk);
        #1;
        t0         = cyc;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] rdata, input int stall, input logic [31:0] exp_data);
        int t0;
        bus_exp_t b;
        wb_exp_t  w;
        drive_req(1'b0, f3, addr, 32'h0, rd, t0);
        b.addr = {addr[31:2], 2'b00}; b.we = 1'b0; b.strb = 4'h0; b.wdata = 32'h0; b.cyc = t0 + 1 + stall;
        bus_q.push_back(b);
        if (rd != 5'd0) begin
            w.rd = rd; w.data = exp_data; w.cyc = t0 + 3 + stall;
            wb_q.push_back(w);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
        end
        bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = rdata;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
        chk("ready_after_load", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        int t0;
        bus_exp_t b;
        drive_req(1'b1, f3, addr, wdata, 5'd0, t0);
        b.addr = {addr[31:2], 2'b00}; b.we = 1'b1; b.strb = exp_strb; b.wdata = exp_wdata; b.cyc = t0 + 1;
        bus_q.push_back(b);
        @(posedge clk); #1;
        req_valid = 1'b0;
        bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        chk("ready_after_store", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic do_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        int t0;
        drive_req(1'b0, f3, addr, 32'h0, 5'd4, t0);
        mis_q.push_back(t0 + 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("ready_mis_c1", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        chk("ready_mis_c2", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bus_valid"}, {31'd0, bus_valid}, 32'd0);
        chk({tag, "_bus_we"}, {31'd0, bus_we}, 32'd0);
        chk({tag, "_bus_wstrb"}, {28'd0, bus_wstrb}, 32'd0);
        chk({tag, "_bus_addr"}, bus_addr, 32'd0);
        chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
        chk({tag, "_wb_en"}, {31'd0, mem_write_en}, 32'd0);
        chk({tag, "_wb_addr"}, {27'd0, mem_write_addr}, 32'd0);
        chk({tag, "_wb_data"}, mem_write_data, 32'd0);
        chk({tag, "_misaligned"}, {31'd0, misaligned}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int waited;
        bus_exp_t b;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_rd     = 5'd0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // LB sign-extended from top byte lane
        do_load(3'b000, 32'h0000_1003, 5'd5, 32'h80FF_0000, 0, 32'hFFFF_FF80);
        // LHU with 3 cycles of bus backpressure
        do_load(3'b101, 32'h0000_2002, 5'd6, 32'hBEEF_1234, 3, 32'h0000_BEEF);
        // LH sign-extends the same halfword
        do_load(3'b001, 32'h0000_2002, 5'd8, 32'hBEEF_1234, 0, 32'hFFFF_BEEF);
        // LBU zero-extends from lane 1
        do_load(3'b100, 32'h0000_0001, 5'd10, 32'h0000_9A00, 1, 32'h0000_009A);
        // LW full word
        do_load(3'b010, 32'h0000_0020, 5'd3, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);

        // Stores: strobes and lane replication
        do_store(3'b000, 32'h0000_0011, 32'h1234_56AB, 4'b0010, 32'hABAB_ABAB);
        do_store(3'b001, 32'h0000_0012, 32'h1234_56AB, 4'b1100, 32'h56AB_56AB);
        do_store(3'b010, 32'h0000_0100, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        // Misaligned accesses are rejected without a bus request
        do_misaligned(3'b010, 32'h0000_0006);
        do_misaligned(3'b101, 32'h0000_0003);

        // Load to rd 0: bus access but no writeback
        do_load(3'b010, 32'h0000_0008, 5'd0, 32'h1111_2222, 0, 32'h0);

        // Illegal funct3 dropped silently: no bus, no misaligned
        drive_req(1'b0, 3'b011, 32'h0000_0040, 32'h0, 5'd2, t0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("illegal_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;

        // Load to rd 7, reset pulsed while waiting for read data
        drive_req(1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd7, t0);
        b.addr = 32'h0000_0040; b.we = 1'b0; b.strb = 4'h0; b.wdata = 32'h0; b.cyc = t0 + 1;
        bus_q.push_back(b);
        @(posedge clk); #1;
        req_valid = 1'b0;
        bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        chk("wait_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h7777_7777;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_ready", {31'd0, req_ready}, 32'd1);

        // Normal LW after reset recovery
        do_load(3'b010, 32'h0000_0044, 5'd9, 32'h0BAD_F00D, 0, 32'h0BAD_F00D);

        waited = 0;
        while ((bus_q.size() != 0 || wb_q.size() != 0 || mis_q.size() != 0) && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        repeat (2) @(posedge clk);
        chk("bus_q_drained", bus_q.size(), 32'd0);
        chk("wb_q_drained", wb_q.size(), 32'd0);
        chk("mis_q_drained", mis_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
